// File: rtl/axi_slice_pkg.sv
// AXI register slice shared definitions.
// Response codes and burst length width.
package axi_slice_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int AXLEN_W = 8;

endpackage

// File: rtl/axi_if_slice_if.sv
// Reduced AXI4 bus bundle for the register slice.
// master drives requests, slave drives responses.
interface axi_if_slice_if
    import axi_slice_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [AXLEN_W-1:0]      awlen;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic [USER_WIDTH-1:0]   wuser;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic [USER_WIDTH-1:0]   buser;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [AXLEN_W-1:0]      arlen;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [USER_WIDTH-1:0]   ruser;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bresp, buser, bvalid,
        output bready,
        output araddr, arlen, arvalid,
        input  arready,
        input  rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bresp, buser, bvalid,
        input  bready,
        input  araddr, arlen, arvalid,
        output arready,
        output rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_skid_buffer.sv
// Two-entry skid buffer: registered valid, ready and data.
// Full throughput, one cycle of latency.
module axi_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_v;
    logic             skid_v;
    logic             rdy_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             load_main;

    assign in_fire   = in_valid & rdy_q;
    assign load_main = ~main_v | out_ready;

    assign in_ready  = rdy_q;
    assign out_valid = main_v;
    assign out_data  = main_q;

    // occupancy flags; ready is low only while the skid entry holds a beat
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
        end else if (load_main) begin
            main_v <= skid_v | in_fire;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            skid_v <= skid_v | in_fire;
            rdy_q  <= ~(skid_v | in_fire);
        end
    end

    // payload: main refills from skid first, stalled arrivals park in skid
    always_ff @(posedge clk) begin
        if (load_main) begin
            main_q <= skid_v ? skid_q : in_data;
        end
        if (~load_main & in_fire) begin
            skid_q <= in_data;
        end
    end

endmodule

// File: rtl/axi_if_slice.sv
// AXI4 register slice: one skid buffer per channel.
// Top only packs and unpacks channel fields.
module axi_if_slice
    import axi_slice_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
) (
    input  logic           aclk,
    input  logic           areset,
    axi_if_slice_if.slave  s_axi,
    axi_if_slice_if.master m_axi
);

    localparam int AW_W = ADDR_WIDTH + AXLEN_W;
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1 + USER_WIDTH;
    localparam int B_W  = 2 + USER_WIDTH;
    localparam int AR_W = ADDR_WIDTH + AXLEN_W;
    localparam int R_W  = DATA_WIDTH + 2 + 1 + USER_WIDTH;

    logic [AW_W-1:0] aw_in, aw_out;
    logic [W_W-1:0]  w_in, w_out;
    logic [B_W-1:0]  b_in, b_out;
    logic [AR_W-1:0] ar_in, ar_out;
    logic [R_W-1:0]  r_in, r_out;

    assign aw_in = {s_axi.awaddr, s_axi.awlen};
    assign {m_axi.awaddr, m_axi.awlen} = aw_out;

    assign w_in = {s_axi.wdata, s_axi.wstrb, s_axi.wlast, s_axi.wuser};
    assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wuser} = w_out;

    assign b_in = {m_axi.bresp, m_axi.buser};
    assign {s_axi.bresp, s_axi.buser} = b_out;

    assign ar_in = {s_axi.araddr, s_axi.arlen};
    assign {m_axi.araddr, m_axi.arlen} = ar_out;

    assign r_in = {m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.ruser};
    assign {s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.ruser} = r_out;

    axi_skid_buffer #(.WIDTH(AW_W)) u_aw (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (s_axi.awvalid),
        .in_ready  (s_axi.awready),
        .in_data   (aw_in),
        .out_valid (m_axi.awvalid),
        .out_ready (m_axi.awready),
        .out_data  (aw_out)
    );

    axi_skid_buffer #(.WIDTH(W_W)) u_w (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (s_axi.wvalid),
        .in_ready  (s_axi.wready),
        .in_data   (w_in),
        .out_valid (m_axi.wvalid),
        .out_ready (m_axi.wready),
        .out_data  (w_out)
    );

    axi_skid_buffer #(.WIDTH(B_W)) u_b (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (m_axi.bvalid),
        .in_ready  (m_axi.bready),
        .in_data   (b_in),
        .out_valid (s_axi.bvalid),
        .out_ready (s_axi.bready),
        .out_data  (b_out)
    );

    axi_skid_buffer #(.WIDTH(AR_W)) u_ar (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (s_axi.arvalid),
        .in_ready  (s_axi.arready),
        .in_data   (ar_in),
        .out_valid (m_axi.arvalid),
        .out_ready (m_axi.arready),
        .out_data  (ar_out)
    );

    axi_skid_buffer #(.WIDTH(R_W)) u_r (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (m_axi.rvalid),
        .in_ready  (m_axi.rready),
        .in_data   (r_in),
        .out_valid (s_axi.rvalid),
        .out_ready (s_axi.rready),
        .out_data  (r_out)
    );

endmodule

// File: tb/tb_axi_if_slice.sv
// Directed bench for the AXI register slice.
// Inputs change 1 ns after the rising edge; outputs checked there too.
module tb_axi_if_slice;
    import axi_slice_pkg::*;

    logic aclk = 1'b0;
    logic areset;

    int vectors = 0;
    int errs = 0;
    int sent;
    int rcv;

    axi_if_slice_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .USER_WIDTH(1)) up ();
    axi_if_slice_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .USER_WIDTH(1)) dn ();

    axi_if_slice #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32),
        .USER_WIDTH(1)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .s_axi  (up.slave),
        .m_axi  (dn.master)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        areset = 1'b1;
        up.awaddr = '0; up.awlen = '0; up.awvalid = 1'b0;
        up.wdata = '0; up.wstrb = '0; up.wlast = 1'b0;
        up.wuser = '0; up.wvalid = 1'b0;
        up.bready = 1'b1;
        up.araddr = '0; up.arlen = '0; up.arvalid = 1'b0;
        up.rready = 1'b1;
        dn.awready = 1'b1;
        dn.wready = 1'b1;
        dn.bresp = '0; dn.buser = '0; dn.bvalid = 1'b0;
        dn.arready = 1'b1;
        dn.rdata = '0; dn.rresp = '0; dn.rlast = 1'b0;
        dn.ruser = '0; dn.rvalid = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_awvalid", dn.awvalid, 0);
        chk("rst_wvalid", dn.wvalid, 0);
        chk("rst_bvalid", up.bvalid, 0);
        chk("rst_arvalid", dn.arvalid, 0);
        chk("rst_rvalid", up.rvalid, 0);
        chk("rst_awready", up.awready, 0);
        chk("rst_wready", up.wready, 0);
        chk("rst_bready", dn.bready, 0);
        chk("rst_arready", up.arready, 0);
        chk("rst_rready", dn.rready, 0);
        areset = 1'b0;
        tick();
        chk("rel_awready", up.awready, 1);
        chk("rel_wready", up.wready, 1);
        chk("rel_bready", dn.bready, 1);
        chk("rel_arready", up.arready, 1);
        chk("rel_rready", dn.rready, 1);

        // pass-through write: AW
        up.awaddr = 10'h040; up.awlen = 8'd3; up.awvalid = 1'b1;
        tick();
        up.awvalid = 1'b0;
        chk("wr_awvalid", dn.awvalid, 1);
        chk("wr_awaddr", dn.awaddr, 10'h040);
        chk("wr_awlen", dn.awlen, 8'd3);
        tick();
        chk("wr_aw_drain", dn.awvalid, 0);

        // pass-through write: 4 W beats
        for (int i = 0; i < 4; i++) begin
            up.wvalid = 1'b1;
            up.wdata = 32'h11111111 * (i + 1);
            up.wstrb = 4'hF;
            up.wlast = (i == 3);
            up.wuser = 1'b0;
            tick();
            chk("wr_wvalid", dn.wvalid, 1);
            chk("wr_wdata", dn.wdata, 32'h11111111 * (i + 1));
            chk("wr_wstrb", dn.wstrb, 4'hF);
            chk("wr_wlast", dn.wlast, (i == 3));
        end
        up.wvalid = 1'b0;
        up.wlast = 1'b0;
        tick();
        chk("wr_w_drain", dn.wvalid, 0);

        // write response
        dn.bvalid = 1'b1; dn.bresp = OKAY; dn.buser = 1'b1;
        tick();
        dn.bvalid = 1'b0;
        chk("wr_bvalid", up.bvalid, 1);
        chk("wr_bresp", up.bresp, 2'b00);
        chk("wr_buser", up.buser, 1);
        tick();
        chk("wr_b_drain", up.bvalid, 0);

        // pass-through read
        up.araddr = 10'h3FC; up.arlen = 8'd0; up.arvalid = 1'b1;
        tick();
        up.arvalid = 1'b0;
        chk("rd_arvalid", dn.arvalid, 1);
        chk("rd_araddr", dn.araddr, 10'h3FC);
        chk("rd_arlen", dn.arlen, 0);
        dn.rvalid = 1'b1; dn.rdata = 32'hDEADBEEF;
        dn.rresp = SLVERR; dn.rlast = 1'b1; dn.ruser = 1'b0;
        tick();
        dn.rvalid = 1'b0;
        chk("rd_ar_drain", dn.arvalid, 0);
        chk("rd_rvalid", up.rvalid, 1);
        chk("rd_rdata", up.rdata, 32'hDEADBEEF);
        chk("rd_rresp", up.rresp, 2'b10);
        chk("rd_rlast", up.rlast, 1);
        tick();
        chk("rd_r_drain", up.rvalid, 0);

        // backpressure: downstream stalls cycles 3..5, upstream stalls 4..6
        sent = 0;
        rcv = 0;
        for (int c = 0; c < 20; c++) begin
            up.wvalid = (sent < 8);
            up.wdata = 32'hA0 + sent;
            up.wstrb = 4'hF;
            up.wlast = (sent == 7);
            dn.wready = !(c >= 3 && c <= 5);
            chk("bp_wready", up.wready, (c >= 4 && c <= 6) ? 0 : 1);
            #3;
            if (dn.wvalid && dn.wready) begin
                chk("bp_wdata", dn.wdata, 32'hA0 + rcv);
                chk("bp_wlast", dn.wlast, (rcv == 7));
                rcv++;
            end
            if (up.wvalid && up.wready) sent++;
            tick();
        end
        up.wvalid = 1'b0;
        dn.wready = 1'b1;
        chk("bp_sent", sent, 8);
        chk("bp_rcvd", rcv, 8);

        // full throughput on R
        for (int i = 0; i < 16; i++) begin
            dn.rvalid = 1'b1;
            dn.rdata = 32'h100 + i;
            dn.rresp = OKAY;
            dn.rlast = (i == 15);
            chk("ft_rready", dn.rready, 1);
            tick();
            chk("ft_rvalid", up.rvalid, 1);
            chk("ft_rdata", up.rdata, 32'h100 + i);
        end
        dn.rvalid = 1'b0;
        tick();
        chk("ft_drain", up.rvalid, 0);

        // reset with two AR beats buffered
        dn.arready = 1'b0;
        up.arvalid = 1'b1; up.araddr = 10'h111; up.arlen = 8'd1;
        tick();
        up.araddr = 10'h222;
        tick();
        up.arvalid = 1'b0;
        chk("rs_full_ready", up.arready, 0);
        chk("rs_full_valid", dn.arvalid, 1);
        chk("rs_head_addr", dn.araddr, 10'h111);
        areset = 1'b1;
        tick();
        chk("rs_arvalid", dn.arvalid, 0);
        chk("rs_arready", up.arready, 0);
        tick();
        chk("rs_arvalid2", dn.arvalid, 0);
        chk("rs_arready2", up.arready, 0);
        areset = 1'b0;
        dn.arready = 1'b1;
        tick();
        chk("rs_rel_ready", up.arready, 1);
        chk("rs_rel_valid", dn.arvalid, 0);
        tick();
        chk("rs_no_ghost", dn.arvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
